// File: rtl/logic_axi4_lite_register_slave.sv
// AXI4-Lite slave terminating in a bank of 32-bit control/status registers.
// AW/W are buffered independently and commit together; reads complete one cycle after AR.
module logic_axi4_lite_register_slave #(
   parameter int                   ADDRESS_WIDTH   = 12,
   parameter int                   REGISTERS       = 16,
   parameter logic [REGISTERS-1:0] READ_ONLY_MASK  = '0,
   parameter bit                   PRIVILEGED_ONLY = 1'b0
) (
   input  logic                      aclk,
   input  logic                      areset_n,
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [ADDRESS_WIDTH-1:0]  awaddr,
   input  logic [2:0]                awprot,
   input  logic                      wvalid,
   output logic                      wready,
   input  logic [31:0]               wdata,
   input  logic [3:0]                wstrb,
   output logic                      bvalid,
   input  logic                      bready,
   output logic [1:0]                bresp,
   input  logic                      arvalid,
   output logic                      arready,
   input  logic [ADDRESS_WIDTH-1:0]  araddr,
   input  logic [2:0]                arprot,
   output logic                      rvalid,
   input  logic                      rready,
   output logic [31:0]               rdata,
   output logic [1:0]                rresp,
   output logic [32*REGISTERS-1:0]   control_out,
   input  logic [32*REGISTERS-1:0]   status_in,
   output logic [REGISTERS-1:0]      write_pulse
);
   localparam int IW = ADDRESS_WIDTH - 2;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

   logic                         rdy_en;
   logic                         aw_held, w_held, ar_held;
   logic [IW-1:0]                aw_idx, ar_idx;
   logic                         aw_priv, ar_priv;
   logic [31:0]                  w_data;
   logic [3:0]                   w_strb;
   logic [REGISTERS-1:0][31:0]   regs;
   logic                         commit, wr_ok;
   logic [1:0]                   wr_resp, rd_resp;
   logic [31:0]                  rd_val;
   logic                         unused_bits;

   function automatic logic [1:0] decode(input logic [IW-1:0] idx, input logic priv,
                                         input logic is_write);
      logic ro;
      ro = 1'b0;
      for (int i = 0; i < REGISTERS; i++)
         if (idx == IW'(i)) ro = READ_ONLY_MASK[i];
      if (32'(idx) >= REGISTERS)        return DECERR;
      else if (PRIVILEGED_ONLY && !priv) return SLVERR;
      else if (is_write && ro)           return SLVERR;
      else                               return OKAY;
   endfunction

   // Ready flags stay low through reset and rise on the first edge after release.
   assign awready = rdy_en && !aw_held && !bvalid;
   assign wready  = rdy_en && !w_held && !bvalid;
   assign arready = rdy_en && !rvalid && !ar_held;

   assign commit  = aw_held && w_held;
   assign wr_resp = decode(aw_idx, aw_priv, 1'b1);
   assign wr_ok   = commit && (wr_resp == OKAY);
   assign rd_resp = decode(ar_idx, ar_priv, 1'b0);

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < REGISTERS; i++)
         if (ar_idx == IW'(i))
            rd_val = READ_ONLY_MASK[i] ? status_in[32*i +: 32] : regs[i];
   end

   assign control_out = regs;
   assign unused_bits = ^{awaddr[1:0], araddr[1:0], awprot[2:1], arprot[2:1], status_in};

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         rdy_en      <= 1'b0;
         aw_held     <= 1'b0;
         w_held      <= 1'b0;
         aw_idx      <= '0;
         aw_priv     <= 1'b0;
         w_data      <= '0;
         w_strb      <= '0;
         bvalid      <= 1'b0;
         bresp       <= OKAY;
         write_pulse <= '0;
         regs        <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (awvalid && awready) begin
            aw_held <= 1'b1;
            aw_idx  <= awaddr[ADDRESS_WIDTH-1:2];
            aw_priv <= awprot[0];
         end
         if (wvalid && wready) begin
            w_held <= 1'b1;
            w_data <= wdata;
            w_strb <= wstrb;
         end
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_resp;
         end else if (bvalid && bready) begin
            bvalid <= 1'b0;
         end
         for (int i = 0; i < REGISTERS; i++) begin
            write_pulse[i] <= wr_ok && (aw_idx == IW'(i));
            if (wr_ok && (aw_idx == IW'(i)) && !READ_ONLY_MASK[i])
               for (int b = 0; b < 4; b++)
                  if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         ar_held <= 1'b0;
         ar_idx  <= '0;
         ar_priv <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= '0;
         rresp   <= OKAY;
      end else begin
         if (arvalid && arready) begin
            ar_held <= 1'b1;
            ar_idx  <= araddr[ADDRESS_WIDTH-1:2];
            ar_priv <= arprot[0];
         end
         // regs sampled here are pre-commit, so a same-edge write is not visible.
         if (ar_held) begin
            ar_held <= 1'b0;
            rvalid  <= 1'b1;
            rresp   <= rd_resp;
            rdata   <= (rd_resp == OKAY) ? rd_val : 32'h0;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_logic_axi4_lite_register_slave.sv
// Directed bench: reset, split AW/W ordering, backpressure, mid-transaction reset, then a vector table.
module tb_logic_axi4_lite_register_slave;
   localparam int AWD = 12;
   localparam int NR  = 16;

   logic            aclk = 1'b0, areset_n = 1'b0;
   logic            awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
   logic            arvalid = 0, arready, rvalid, rready = 0;
   logic [AWD-1:0]  awaddr = '0, araddr = '0;
   logic [2:0]      awprot = '0, arprot = '0;
   logic [31:0]     wdata = '0, rdata;
   logic [3:0]      wstrb = '0;
   logic [1:0]      bresp, rresp;
   logic [32*NR-1:0] control_out, status_in;
   logic [NR-1:0]   write_pulse;

   int checks = 0, failures = 0;

   logic_axi4_lite_register_slave #(
      .ADDRESS_WIDTH(AWD), .REGISTERS(NR),
      .READ_ONLY_MASK(16'h0004), .PRIVILEGED_ONLY(1'b1)
   ) dut (
      .aclk(aclk), .areset_n(areset_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .control_out(control_out), .status_in(status_in), .write_pulse(write_pulse)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [AWD-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] p, output logic [1:0] resp, output int lat,
                            output logic [NR-1:0] pulse);
      int n;
      @(negedge aclk);
      awvalid = 1; awaddr = a; awprot = p; wvalid = 1; wdata = d; wstrb = s;
      n = 0;
      while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
      @(posedge aclk); #1;
      awvalid = 0; wvalid = 0;
      lat = 0;
      @(negedge aclk);
      while (!bvalid && lat < 20) begin @(negedge aclk); lat++; end
      resp = bresp; pulse = write_pulse;
      bready = 1;
      @(posedge aclk); #1 bready = 0;
   endtask

   task automatic axi_read(input logic [AWD-1:0] a, input logic [2:0] p,
                           output logic [1:0] resp, output logic [31:0] d, output int lat);
      int n;
      @(negedge aclk);
      arvalid = 1; araddr = a; arprot = p;
      n = 0;
      while (!arready && n < 20) begin @(negedge aclk); n++; end
      @(posedge aclk); #1 arvalid = 0;
      lat = 0;
      @(negedge aclk);
      while (!rvalid && lat < 20) begin @(negedge aclk); lat++; end
      resp = rresp; d = rdata;
      rready = 1;
      @(posedge aclk); #1 rready = 0;
   endtask

   typedef struct {
      bit              wr;
      logic [AWD-1:0]  addr;
      logic [31:0]     data;
      logic [3:0]      strb;
      logic [2:0]      prot;
      logic [1:0]      resp;
      logic [31:0]     exp;    // read data, or register ci value after a write
      int              ci;
      logic [NR-1:0]   pulse;
   } vec_t;

   vec_t vt[17];

   initial begin
      logic [1:0]    resp;
      logic [31:0]   d;
      logic [NR-1:0] pulse;
      int            lat;

      vt[0]  = '{1, 12'h004, 32'hDEADBEEF, 4'hF, 3'b001, 2'b00, 32'hDEADBEEF, 1,  16'h0002};
      vt[1]  = '{0, 12'h004, 32'h0,        4'h0, 3'b001, 2'b00, 32'hDEADBEEF, 0,  16'h0000};
      vt[2]  = '{0, 12'h040, 32'h0,        4'h0, 3'b001, 2'b11, 32'h00000000, 0,  16'h0000};
      vt[3]  = '{1, 12'h040, 32'h55555555, 4'hF, 3'b001, 2'b11, 32'hDEADBEEF, 1,  16'h0000};
      vt[4]  = '{0, 12'h008, 32'h0,        4'h0, 3'b001, 2'b00, 32'h12345678, 0,  16'h0000};
      vt[5]  = '{1, 12'h008, 32'h99999999, 4'hF, 3'b001, 2'b10, 32'h00000000, 2,  16'h0000};
      vt[6]  = '{1, 12'h00C, 32'h11223344, 4'hF, 3'b000, 2'b10, 32'h00000000, 3,  16'h0000};
      vt[7]  = '{0, 12'h00C, 32'h0,        4'h0, 3'b001, 2'b00, 32'h00000000, 0,  16'h0000};
      vt[8]  = '{1, 12'h00C, 32'h11223344, 4'hF, 3'b001, 2'b00, 32'h11223344, 3,  16'h0008};
      vt[9]  = '{0, 12'h00C, 32'h0,        4'h0, 3'b001, 2'b00, 32'h11223344, 0,  16'h0000};
      vt[10] = '{0, 12'h00C, 32'h0,        4'h0, 3'b000, 2'b10, 32'h00000000, 0,  16'h0000};
      vt[11] = '{1, 12'h00F, 32'hAABBCCDD, 4'h5, 3'b001, 2'b00, 32'h11BB33DD, 3,  16'h0008};
      vt[12] = '{1, 12'h00C, 32'hFFFFFFFF, 4'h0, 3'b001, 2'b00, 32'h11BB33DD, 3,  16'h0008};
      vt[13] = '{0, 12'h00E, 32'h0,        4'h0, 3'b001, 2'b00, 32'h11BB33DD, 0,  16'h0000};
      vt[14] = '{0, 12'hFFC, 32'h0,        4'h0, 3'b001, 2'b11, 32'h00000000, 0,  16'h0000};
      vt[15] = '{1, 12'h03C, 32'hCAFEF00D, 4'hF, 3'b001, 2'b00, 32'hCAFEF00D, 15, 16'h8000};
      vt[16] = '{0, 12'h03C, 32'h0,        4'h0, 3'b001, 2'b00, 32'hCAFEF00D, 0,  16'h0000};

      status_in = '0;
      status_in[64 +: 32] = 32'h12345678;

      // Reset state and ready release
      repeat (2) @(negedge aclk);
      check("rst_bvalid", 32'(bvalid), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_readies", {29'd0, awready, wready, arready}, 0);
      check("rst_resp", {28'd0, bresp, rresp}, 0);
      check("rst_ctrl_lo", control_out[31:0], 0);
      check("rst_pulse", 32'(write_pulse), 0);
      areset_n = 1;
      #2 check("ready_before_edge", {29'd0, awready, wready, arready}, 0);
      @(negedge aclk);
      check("ready_after_edge", {29'd0, awready, wready, arready}, 32'h7);

      // W first, AW three cycles later
      wvalid = 1; wdata = 32'h0000AB00; wstrb = 4'b0010;
      @(posedge aclk); #1 wvalid = 0;
      repeat (3) @(negedge aclk);
      check("wfirst_no_bvalid", 32'(bvalid), 0);
      check("wfirst_wready_low", {30'd0, wready, awready}, 32'h1);
      awvalid = 1; awaddr = 12'h004; awprot = 3'b001;
      @(posedge aclk); #1 awvalid = 0;
      lat = 0;
      @(negedge aclk);
      while (!bvalid && lat < 20) begin @(negedge aclk); lat++; end
      check("wfirst_latency", 32'(lat), 1);
      check("wfirst_bresp", 32'(bresp), 0);
      check("wfirst_reg1", control_out[32 +: 32], 32'h0000AB00);
      check("wfirst_pulse", 32'(write_pulse), 32'h0002);

      // Backpressure on B for five cycles
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         check("bp_bvalid_bresp", {29'd0, bvalid, bresp}, 32'h4);
         check("bp_readies", {30'd0, awready, wready}, 0);
         if (i == 0) check("pulse_one_cycle", 32'(write_pulse), 0);
      end
      bready = 1;
      @(posedge aclk); #1 bready = 0;
      @(negedge aclk);
      check("bp_released", {29'd0, bvalid, awready, wready}, 32'h3);

      // Reset with W held and R pending
      wvalid = 1; wdata = 32'h77777777; wstrb = 4'hF;
      arvalid = 1; araddr = 12'h004; arprot = 3'b001;
      @(posedge aclk); #1 wvalid = 0; arvalid = 0;
      repeat (2) @(negedge aclk);
      check("mid_rvalid_pending", 32'(rvalid), 1);
      #2 areset_n = 0;
      #1;
      check("mid_rst_valids", {30'd0, bvalid, rvalid}, 0);
      check("mid_rst_readies", {29'd0, awready, wready, arready}, 0);
      check("mid_rst_reg1", control_out[32 +: 32], 0);
      @(negedge aclk);
      areset_n = 1;
      @(negedge aclk);
      awvalid = 1; awaddr = 12'h014; awprot = 3'b001;
      @(posedge aclk); #1 awvalid = 0;
      repeat (3) @(negedge aclk);
      check("mid_w_dropped", {30'd0, bvalid, write_pulse[5]}, 0);
      wvalid = 1; wdata = 32'h00000005; wstrb = 4'hF;
      @(posedge aclk); #1 wvalid = 0;
      repeat (2) @(negedge aclk);
      check("mid_recover_bvalid", 32'(bvalid), 1);
      bready = 1;
      @(posedge aclk); #1 bready = 0;

      // Vector table
      foreach (vt[i]) begin
         if (vt[i].wr) begin
            axi_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].prot, resp, lat, pulse);
            check($sformatf("v%0d_bresp", i), 32'(resp), 32'(vt[i].resp));
            check($sformatf("v%0d_pulse", i), 32'(pulse), 32'(vt[i].pulse));
            check($sformatf("v%0d_reg", i), control_out[32*vt[i].ci +: 32], vt[i].exp);
         end else begin
            axi_read(vt[i].addr, vt[i].prot, resp, d, lat);
            check($sformatf("v%0d_rresp", i), 32'(resp), 32'(vt[i].resp));
            check($sformatf("v%0d_rdata", i), d, vt[i].exp);
         end
         check($sformatf("v%0d_latency", i), 32'(lat), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
